// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the core sequencer: FSM states, trap causes, op-class flags.
package core_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEM       = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IFETCH  = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  // Op-class flags as presented by the decoder; bit order {load..alu}.
  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic reg_op;
    logic alu;
  } op_flags_t;

  // Register file is written for anything producing a result; branch and
  // store never write, even if the decoder also raises a result class.
  function automatic logic writes_rf(input op_flags_t f);
    return (f.load | f.reg_op | f.alu | f.jump) & ~(f.branch | f.store);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction/data memory request-ack handshakes between sequencer and memories.
interface core_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/core_sequencer_bus_timeout.sv
// Wait-cycle counter for one outstanding bus request; expired flags the last
// unacked cycle so the FSM can trap instead of waiting again.
module bus_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic ack,
  output logic expired
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  // Clear on entry to a waiting state, count each cycle spent without ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (en && !ack)   cnt <= cnt + 1'b1;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = en && !ack && (cnt == W'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/core_sequencer.sv
// Multicycle control FSM: fetch -> decode -> execute -> (mem) -> writeback,
// with bus timeouts, retire counting and a sticky TRAP state.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  core_sequencer_if.master    bus,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                is_branch,
  input  logic                is_jump,
  input  logic                is_reg,
  input  logic                is_alu,
  input  logic                illegal,
  output logic                ir_we,
  output logic                decode_en,
  output logic                exec_en,
  output logic                rf_we,
  output logic                pc_we,
  output logic                halt,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retire_cnt
);
  logic [2:0] next;
  logic [1:0] next_cause;
  op_flags_t  ops, ops_in;
  logic       waiting, ack, expired, tmo_clr;

  assign ops_in  = '{load: is_load, store: is_store, branch: is_branch,
                     jump: is_jump, reg_op: is_reg, alu: is_alu};
  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign ack     = (state == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
  assign tmo_clr = ((next == ST_FETCH) && (state != ST_FETCH)) ||
                   ((next == ST_MEM)   && (state != ST_MEM));

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .reset(reset), .clr(tmo_clr), .en(waiting), .ack(ack), .expired(expired)
  );

  // Next-state and trap-cause selection; acks only count in their own state.
  always_comb begin
    next       = ST_IDLE;
    next_cause = CAUSE_NONE;
    case (state)
      ST_IDLE:      next = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:
        if (bus.imem_ack)   next = ST_DECODE;
        else if (expired) begin next = ST_TRAP; next_cause = CAUSE_IFETCH; end
        else                next = ST_FETCH;
      ST_DECODE:
        if (illegal || (is_load && is_store)) begin
          next = ST_TRAP; next_cause = CAUSE_ILLEGAL;
        end else next = ST_EXECUTE;
      ST_EXECUTE:   next = (ops.load || ops.store) ? ST_MEM : ST_WRITEBACK;
      ST_MEM:
        if (bus.dmem_ack)   next = ST_WRITEBACK;
        else if (expired) begin next = ST_TRAP; next_cause = CAUSE_DMEM; end
        else                next = ST_MEM;
      ST_WRITEBACK: next = run ? ST_FETCH : ST_IDLE;
      ST_TRAP:      next = ST_TRAP;
      default:      next = ST_IDLE;
    endcase
  end

  // State, trap cause (captured on entry to TRAP), op flags (latched in DECODE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      trap_cause <= CAUSE_NONE;
      ops        <= '0;
    end else begin
      state <= next;
      if ((next == ST_TRAP) && (state != ST_TRAP)) trap_cause <= next_cause;
      if (state == ST_DECODE) ops <= ops_in;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      retire_cnt <= '0;
    else if (state == ST_WRITEBACK)  retire_cnt <= retire_cnt + 1'b1;
  end

  // Datapath controls are Moore on state/ops, except ir_we which follows imem_ack.
  always_comb begin
    bus.imem_req = (state == ST_FETCH);
    ir_we        = (state == ST_FETCH) && bus.imem_ack;
    decode_en    = (state == ST_DECODE);
    exec_en      = (state == ST_EXECUTE);
    bus.dmem_req = (state == ST_MEM);
    bus.dmem_we  = (state == ST_MEM) && ops.store;
    rf_we        = (state == ST_WRITEBACK) && writes_rf(ops);
    pc_we        = (state == ST_WRITEBACK);
    halt         = (state == ST_TRAP);
  end
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: vector table of single instructions plus
// hand-written sequences for reset, run gating, trap persistence, async reset.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        is_load, is_store, is_branch, is_jump, is_reg, is_alu, illegal;
  logic        ir_we, decode_en, exec_en, rf_we, pc_we, halt;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] retire_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  core_sequencer_if bus();

  core_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus.master),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu), .illegal(illegal),
    .ir_we(ir_we), .decode_en(decode_en), .exec_en(exec_en), .rf_we(rf_we), .pc_we(pc_we),
    .halt(halt), .trap_cause(trap_cause), .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ops;    // {load,store,branch,jump,reg,alu}
    logic       ill;
    int         iw;     // imem wait cycles before ack (>=16 means never)
    int         dw;     // dmem wait cycles before ack
    logic [2:0] x_end;  // WRITEBACK or TRAP
    logic       x_rf;
    logic       x_we;
    int         x_mem;  // cycles spent in MEM
    logic [1:0] x_cause;
    int         x_cyc;  // cycles from FETCH entry until terminal state
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    {is_load, is_store, is_branch, is_jump, is_reg, is_alu, illegal} = '0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int fc, mc, cyc;
    logic done, rf, we;
    fc = 0; mc = 0; cyc = 0; done = 1'b0; rf = 1'b0; we = 1'b0;
    do_reset();
    run = 1'b1;
    @(negedge clk);
    while (!done) begin
      clear_in();
      case (state)
        ST_FETCH:  begin bus.imem_ack = (fc == v.iw); fc++; end
        ST_DECODE: begin
          {is_load, is_store, is_branch, is_jump, is_reg, is_alu} = v.ops;
          illegal = v.ill;
        end
        ST_MEM:    begin bus.dmem_ack = (mc == v.dw); mc++; end
        default: ;
      endcase
      #1;
      case (state)
        ST_FETCH:     if (bus.imem_ack) chk($sformatf("v%0d_ir_we", idx), ir_we, 1);
        ST_MEM:       we = we | bus.dmem_we;
        ST_WRITEBACK: begin rf = rf_we; done = 1'b1; chk($sformatf("v%0d_pc_we", idx), pc_we, 1); end
        ST_TRAP:      done = 1'b1;
        default: ;
      endcase
      if (!done) begin
        cyc++;
        if (cyc > 40) begin
          chk($sformatf("v%0d_bound", idx), 0, 1);
          done = 1'b1;
        end else @(negedge clk);
      end
    end
    chk($sformatf("v%0d_end", idx), state, v.x_end);
    chk($sformatf("v%0d_cyc", idx), cyc, v.x_cyc);
    chk($sformatf("v%0d_rf_we", idx), rf, v.x_rf);
    chk($sformatf("v%0d_dmem_we", idx), we, v.x_we);
    chk($sformatf("v%0d_mem_cyc", idx), mc, v.x_mem);
    chk($sformatf("v%0d_cause", idx), trap_cause, v.x_cause);
    if (v.x_end == ST_TRAP) begin
      chk($sformatf("v%0d_halt", idx), halt, 1);
      chk($sformatf("v%0d_reqs", idx), {bus.imem_req, bus.dmem_req}, 0);
    end
    clear_in();
    @(negedge clk);
    chk($sformatf("v%0d_retire", idx), retire_cnt, (v.x_end == ST_WRITEBACK) ? 1 : 0);
  endtask

  initial begin
    //          ops        ill iw  dw  end           rf  we  mem cause          cyc
    vecs[0]  = '{6'b000001, 0, 0,  0,  ST_WRITEBACK, 1, 0, 0,  CAUSE_NONE,    3};
    vecs[1]  = '{6'b000010, 0, 2,  0,  ST_WRITEBACK, 1, 0, 0,  CAUSE_NONE,    5};
    vecs[2]  = '{6'b010000, 0, 0,  3,  ST_WRITEBACK, 0, 1, 4,  CAUSE_NONE,    7};
    vecs[3]  = '{6'b100000, 0, 0,  0,  ST_WRITEBACK, 1, 0, 1,  CAUSE_NONE,    4};
    vecs[4]  = '{6'b001000, 0, 0,  0,  ST_WRITEBACK, 0, 0, 0,  CAUSE_NONE,    3};
    vecs[5]  = '{6'b000100, 0, 1,  0,  ST_WRITEBACK, 1, 0, 0,  CAUSE_NONE,    4};
    vecs[6]  = '{6'b000001, 0, 15, 0,  ST_WRITEBACK, 1, 0, 0,  CAUSE_NONE,    18};
    vecs[7]  = '{6'b000001, 0, 99, 0,  ST_TRAP,      0, 0, 0,  CAUSE_IFETCH,  16};
    vecs[8]  = '{6'b000001, 1, 0,  0,  ST_TRAP,      0, 0, 0,  CAUSE_ILLEGAL, 2};
    vecs[9]  = '{6'b110000, 0, 0,  0,  ST_TRAP,      0, 0, 0,  CAUSE_ILLEGAL, 2};
    vecs[10] = '{6'b100000, 0, 0,  99, ST_TRAP,      0, 0, 16, CAUSE_DMEM,    19};
    vecs[11] = '{6'b010000, 0, 0,  15, ST_WRITEBACK, 0, 1, 16, CAUSE_NONE,    19};

    // Reset held with run=1: everything quiet.
    reset = 1'b0; run = 1'b1; clear_in();
    repeat (3) @(negedge clk);
    chk("rst_state", state, ST_IDLE);
    chk("rst_outs", {bus.imem_req, ir_we, decode_en, exec_en, bus.dmem_req, bus.dmem_we,
                     rf_we, pc_we, halt}, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_cause", trap_cause, 0);
    reset = 1'b1;
    #1 chk("rel_idle", state, ST_IDLE);
    @(negedge clk);
    chk("rel_fetch", state, ST_FETCH);
    chk("rel_imem_req", bus.imem_req, 1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // run dropped in EXECUTE: instruction still retires, then IDLE; run restarts.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0; is_alu = 1'b1;
    #1 chk("seq_decode_en", decode_en, 1);
    @(negedge clk);
    is_alu = 1'b0; run = 1'b0;
    #1 chk("seq_exec_en", exec_en, 1);
    @(negedge clk);
    chk("seq_wb", state, ST_WRITEBACK);
    chk("seq_wb_rf", rf_we, 1);
    @(negedge clk);
    chk("seq_idle", state, ST_IDLE);
    chk("seq_retire1", retire_cnt, 1);
    @(negedge clk);
    chk("seq_idle_hold", state, ST_IDLE);
    run = 1'b1;
    @(negedge clk);
    chk("seq_refetch", state, ST_FETCH);

    // Illegal instruction traps; TRAP ignores run and stray acks.
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0; illegal = 1'b1;
    @(negedge clk);
    illegal = 1'b0;
    chk("trap_state", state, ST_TRAP);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("trap_hold", state, ST_TRAP);
    chk("trap_cause_hold", trap_cause, CAUSE_ILLEGAL);
    chk("trap_no_ir_we", ir_we, 0);
    chk("trap_retire", retire_cnt, 1);

    // Async reset mid-MEM drops dmem_req before the next clock edge.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0; is_store = 1'b1;
    @(negedge clk);
    is_store = 1'b0;
    @(negedge clk);
    chk("amem_req", bus.dmem_req, 1);
    #2 reset = 1'b0;
    #1 chk("amem_drop", bus.dmem_req, 0);
    chk("amem_state", state, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("amem_restart", state, ST_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
